serial_rx_fifo: RTL
===================

SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, receive buffer entries; power of two, 4..256.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_rdy  input  1  byte-valid from serial receiver; held high until acknowledged.
REQ-005 SHALL have port rx_data  input  8  received byte; stable while rx_rdy high.
REQ-006 SHALL have port rx_done  output  1  one-cycle acknowledge to receiver (drives receiver's done).
REQ-007 SHALL have port rd  input  1  CPU data-register read strobe, one cycle per byte.
REQ-008 SHALL have port dout  output  8  head byte, first-word fall-through.
REQ-009 SHALL have port avail  output  1  buffer non-empty.
REQ-010 SHALL have port full  output  1  buffer holds DEPTH bytes.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  bytes held.
REQ-012 SHALL have port ovf  output  1  sticky overrun flag.
REQ-013 SHALL have port ovf_clr  input  1  clears ovf.

Function
REQ-014 SHALL accept a byte in cycle N iff rx_rdy=1, rx_done=0, full=0; write at tail, rx_done=1 in cycle N+1 only.
REQ-015 SHALL ignore rx_rdy while rx_done=1 (receiver drops rdy one cycle after done), so each byte is written exactly once.
REQ-016 SHALL, while full=1 and overrun feature absent, withhold rx_done; receiver stalls, no byte lost.
REQ-017 SHALL present head byte on dout combinationally from storage whenever avail=1; dout undefined-but-stable (last head) when empty.
REQ-018 SHALL pop head on rd=1 with avail=1; rd with avail=0 SHALL be ignored, no state change.
REQ-019 SHALL, on simultaneous accept and pop, keep count unchanged and advance both pointers.
REQ-020 SHALL evaluate full and avail from registered state: at full, same-cycle rd does not enable a write; write enabled next cycle.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count saturates never (0..DEPTH by construction).
REQ-022 SHALL derive full=(count==DEPTH), avail=(count!=0), both registered-consistent with count.
REQ-023 SHALL clear ovf on ovf_clr=1; if set and clear coincide, set wins.

Reset
REQ-024 SHALL, while rst=0, force pointers=0, count=0, rx_done=0, ovf=0, avail=0, full=0, dout=8'h00 from first read after release until first write.
REQ-025 SHALL discard buffer contents on reset mid-operation; a byte still held by receiver (rx_rdy=1) SHALL be accepted on first clk edge after release.

Configuration
REQ-026 SHALL, with macro SERIAL_RX_OVERRUN_EN defined, when rx_rdy=1, rx_done=0, full=1: pulse rx_done next cycle, drop byte, set ovf.
REQ-027 SHALL, without SERIAL_RX_OVERRUN_EN, apply REQ-016 backpressure; ovf tied 0, ovf_clr ignored.

Structure
REQ-028 SHALL place default DEPTH and byte width constant (8) in shared package serial_pkg, used also by serial transmit side.
REQ-029 SHALL implement storage as sub-module serial_rx_fifo_mem (DEPTH x 8, one synchronous write port, one asynchronous read port); control logic in serial_rx_fifo.

Verification
REQ-030 SHALL cover single byte: rx_rdy with 8'h41 held until done -> rx_done one cycle after, avail=1, dout=8'h41, count=1; rd -> avail=0.
REQ-031 SHALL cover no double-accept: rx_rdy held through rx_done cycle -> exactly one write, count=1.
REQ-032 SHALL cover fill to DEPTH=16 with 8'h00..8'h0F then byte 8'h10 waiting -> full=1, no rx_done; one rd returns 8'h00 -> 8'h10 accepted next cycle, count=16, last read yields 8'h10 after wrap.
REQ-033 SHALL cover simultaneous rd and accept at count=5 -> count stays 5, order preserved.
REQ-034 SHALL cover overrun build (SERIAL_RX_OVERRUN_EN): 17 bytes without rd -> 17th acknowledged and dropped, ovf=1, count=16; ovf_clr -> ovf=0.
REQ-035 SHALL cover reset with count=7 and rx_rdy=1 -> count=0 during reset, byte accepted first edge after release, count=1.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial constants for the receive and transmit sides
package serial_pkg;

   // Default receive/transmit buffer depth in bytes (power of two, 4..256)
   localparam int SERIAL_DEPTH_DEFAULT = 16;

   // Width of one serial character
   localparam int SERIAL_BYTE_W = 8;

endpackage

// File: rtl/serial_rx_fifo_if.sv
// rtl/serial_rx_fifo_if.sv - receiver/CPU handshake bundle for serial_rx_fifo
interface serial_rx_fifo_if
   import serial_pkg::*;
#(
   parameter int DEPTH = SERIAL_DEPTH_DEFAULT
);
   localparam int CW = $clog2(DEPTH) + 1;

   // receiver side
   logic                     rx_rdy;
   logic [SERIAL_BYTE_W-1:0] rx_data;
   logic                     rx_done;
   // CPU side
   logic                     rd;
   logic [SERIAL_BYTE_W-1:0] dout;
   logic                     avail;
   logic                     full;
   logic [CW-1:0]            count;
   logic                     ovf;
   logic                     ovf_clr;

   // fifo side
   modport slave (
      input  rx_rdy, rx_data, rd, ovf_clr,
      output rx_done, dout, avail, full, count, ovf
   );

   // receiver + CPU side
   modport master (
      output rx_rdy, rx_data, rd, ovf_clr,
      input  rx_done, dout, avail, full, count, ovf
   );

endinterface

// File: rtl/serial_rx_fifo_mem.sv
// rtl/serial_rx_fifo_mem.sv - DEPTH x W storage, sync write port, async read port
module serial_rx_fifo_mem
   import serial_pkg::*;
#(
   parameter int DEPTH = SERIAL_DEPTH_DEFAULT,
   parameter int W     = SERIAL_BYTE_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   // write the accepted byte at the tail; storage itself is never reset
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/serial_rx_fifo.sv
// rtl/serial_rx_fifo.sv - serial receive byte buffer, FWFT; overrun drop mode under SERIAL_RX_OVERRUN_EN
module serial_rx_fifo
   import serial_pkg::*;
#(
   parameter int DEPTH = SERIAL_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   serial_rx_fifo_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]            r_wr_ptr;
   logic [AW-1:0]            r_rd_ptr;
   logic [CW-1:0]            r_count;
   logic                     r_rx_done;
   logic                     r_full;
   logic                     r_avail;
   logic [SERIAL_BYTE_W-1:0] r_dout_hold;

   logic                     w_accept;
   logic                     w_pop;
   logic [CW-1:0]            w_count_nxt;
   logic [SERIAL_BYTE_W-1:0] w_mem_rdata;

   // A byte is taken only when the receiver offers it, we are not in the
   // acknowledge cycle of the previous byte, and there is room.  Both
   // conditions use registered flags, so a read at full never frees a slot
   // for the same cycle.
   assign w_accept = bus.rx_rdy & ~r_rx_done & ~r_full;
   assign w_pop    = bus.rd & r_avail;

   // next occupancy: simultaneous accept and pop leave it unchanged
   always_comb begin
      w_count_nxt = r_count;
      if (w_accept && !w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_pop && !w_accept) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   serial_rx_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (SERIAL_BYTE_W),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_accept),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.rx_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_mem_rdata)
   );

`ifdef SERIAL_RX_OVERRUN_EN
   logic w_drop;
   logic r_ovf;

   // byte offered while full: acknowledge it anyway and throw it away
   assign w_drop = bus.rx_rdy & ~r_rx_done & r_full;

   // sticky overrun flag; a new overrun beats a simultaneous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign bus.ovf = r_ovf;
`else
   logic w_drop;
   logic w_unused_ovf_clr;

   // without overrun mode a full buffer simply withholds the acknowledge
   assign w_drop           = 1'b0;
   assign w_unused_ovf_clr = bus.ovf_clr;
   assign bus.ovf          = 1'b0;
`endif

   // pointers, occupancy, flags and the one-cycle receiver acknowledge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rx_done <= 1'b0;
         r_full    <= 1'b0;
         r_avail   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count   <= w_count_nxt;
         r_rx_done <= w_accept | w_drop;
         r_full    <= (w_count_nxt == CW'(DEPTH));
         r_avail   <= (w_count_nxt != '0);
      end
   end

   // remember the byte being popped so dout stays stable once empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout_hold <= '0;
      end else if (w_pop) begin
         r_dout_hold <= w_mem_rdata;
      end
   end

   assign bus.dout    = r_avail ? w_mem_rdata : r_dout_hold;
   assign bus.rx_done = r_rx_done;
   assign bus.avail   = r_avail;
   assign bus.full    = r_full;
   assign bus.count   = r_count;

endmodule
